// File: rtl/midi_syx_pkg.sv
// ---------------------------------------------------------------------------
// midi_syx_pkg
// Shared definitions for the SysEx patch-dump transmitter:
//   - SysEx framing bytes and the data-set command code
//   - FSM state encoding
//   - checksum finaliser: (128 - running sum) mod 128
// ---------------------------------------------------------------------------
package midi_syx_pkg;

  localparam logic [7:0] SYX_SOX     = 8'hF0;
  localparam logic [7:0] SYX_EOX     = 8'hF7;
  localparam logic [7:0] SYX_CMD_DT1 = 8'h12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOX,
    ST_MFR,
    ST_DEV,
    ST_CMD,
    ST_AHI,
    ST_ALO,
    ST_FETCH,
    ST_DATA,
    ST_CSUM,
    ST_EOX
  } syx_state_e;

  function automatic logic [6:0] syx_csum(input logic [6:0] sum);
    return 7'(8'd128 - {1'b0, sum});
  endfunction

endpackage

// File: rtl/syx_csum_acc.sv
// ---------------------------------------------------------------------------
// syx_csum_acc
// 7-bit modulo-128 running sum for the SysEx checksum.
// Ports:
//   reg_clk      clock
//   reset_reg_N  async active-low reset, clears the sum
//   clr          synchronous clear (new frame)
//   add_en       add add_val this cycle
//   add_val      7-bit value to accumulate
//   sum          current running sum
// ---------------------------------------------------------------------------
module syx_csum_acc (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       clr,
  input  logic       add_en,
  input  logic [6:0] add_val,
  output logic [6:0] sum
);

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_val;
    end
  end

endmodule

// File: rtl/midi_syx_dump_tx.sv
// ---------------------------------------------------------------------------
// midi_syx_dump_tx
// Reads a span of patch RAM and sends it to the MIDI UART as a checksummed
// SysEx data-set frame: F0 MFR ch 12 ahi alo data... csum F7.
// Ports:
//   reg_clk, reset_reg_N          clock, async active-low reset
//   midi_ch, dump_addr, dump_len  frame parameters, latched on accepted start
//   dump_start                    one-cycle request
//   dump_abort                    end the frame early with F7
//   ram_addr, ram_rd, ram_q       patch RAM read port (1-cycle latency)
//   tx_data, tx_valid, tx_ready   byte stream to the UART
//   busy                          frame in progress
//   dump_done/aborted/rejected    one-cycle status pulses
//
// state  | meaning
// IDLE   | waiting for dump_start
// SOX    | sending F0
// MFR    | sending manufacturer ID
// DEV    | sending {0, channel}
// CMD    | sending data-set command 12
// AHI    | sending address bits 13..7
// ALO    | sending address bits 6..0
// FETCH  | RAM read strobe, no byte offered
// DATA   | sending masked RAM byte
// CSUM   | sending checksum
// EOX    | sending F7
// ---------------------------------------------------------------------------
module midi_syx_dump_tx
  import midi_syx_pkg::*;
#(
  parameter logic [7:0] MFR_ID = 8'h7D,
  parameter int         ADDR_W = 8
) (
  input  logic              reg_clk,
  input  logic              reset_reg_N,
  input  logic [3:0]        midi_ch,
  input  logic              dump_start,
  input  logic              dump_abort,
  input  logic [ADDR_W-1:0] dump_addr,
  input  logic [ADDR_W:0]   dump_len,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              dump_done,
  output logic              dump_aborted,
  output logic              dump_rejected
);

  syx_state_e        state, state_nxt;
  logic [3:0]        ch_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              abort_q;
  logic              data_held;
  logic [7:0]        data_q;
  logic              rej_pend;
  logic [6:0]        csum_sum;
  logic [13:0]       addr_ext;
  logic [7:0]        ram_q_masked;

  logic hs;
  logic start_ok;
  logic start_rej;
  logic abort_win;
  logic abort_act;
  logic frame_end;
  logic csum_add;

  assign hs           = tx_valid & tx_ready;
  assign start_ok     = dump_start && (state == ST_IDLE) && (dump_len != '0);
  assign start_rej    = dump_start && !start_ok;
  assign abort_win    = state inside {ST_MFR, ST_DEV, ST_CMD, ST_AHI, ST_ALO,
                                      ST_FETCH, ST_DATA, ST_CSUM};
  assign abort_act    = abort_q | (dump_abort & abort_win);
  assign frame_end    = (state == ST_EOX) && hs;
  assign csum_add     = hs && (state inside {ST_AHI, ST_ALO, ST_DATA});
  assign addr_ext     = 14'(addr_q);
  assign ram_q_masked = ram_q & 8'h7F;
  assign ram_addr     = addr_q;

  syx_csum_acc u_csum (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .clr         (start_ok),
    .add_en      (csum_add),
    .add_val     (tx_data[6:0]),
    .sum         (csum_sum)
  );

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_SOX;
      ST_SOX:   if (hs) state_nxt = ST_MFR;
      ST_MFR:   if (hs) state_nxt = abort_act ? ST_EOX : ST_DEV;
      ST_DEV:   if (hs) state_nxt = abort_act ? ST_EOX : ST_CMD;
      ST_CMD:   if (hs) state_nxt = abort_act ? ST_EOX : ST_AHI;
      ST_AHI:   if (hs) state_nxt = abort_act ? ST_EOX : ST_ALO;
      ST_ALO:   if (hs) state_nxt = abort_act ? ST_EOX : ST_FETCH;
      ST_FETCH: state_nxt = abort_act ? ST_EOX : ST_DATA;
      ST_DATA: begin
        if (hs) begin
          if (abort_act)                        state_nxt = ST_EOX;
          else if (cnt_q == (ADDR_W+1)'(1))     state_nxt = ST_CSUM;
          else                                  state_nxt = ST_FETCH;
        end
      end
      ST_CSUM:  if (hs) state_nxt = ST_EOX;
      ST_EOX:   if (hs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    ram_rd   = 1'b0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_SOX:   begin tx_valid = 1'b1; tx_data = SYX_SOX;                end
      ST_MFR:   begin tx_valid = 1'b1; tx_data = {1'b0, MFR_ID[6:0]};    end
      ST_DEV:   begin tx_valid = 1'b1; tx_data = {4'h0, ch_q};           end
      ST_CMD:   begin tx_valid = 1'b1; tx_data = SYX_CMD_DT1;            end
      ST_AHI:   begin tx_valid = 1'b1; tx_data = {1'b0, addr_ext[13:7]}; end
      ST_ALO:   begin tx_valid = 1'b1; tx_data = {1'b0, addr_ext[6:0]};  end
      ST_FETCH: ram_rd = 1'b1;
      ST_DATA: begin
        tx_valid = 1'b1;
        // ram_q is only guaranteed in the first DATA cycle; later cycles
        // of a stalled byte replay the captured copy.
        tx_data  = data_held ? data_q : ram_q_masked;
      end
      ST_CSUM:  begin tx_valid = 1'b1; tx_data = {1'b0, syx_csum(csum_sum)}; end
      ST_EOX:   begin tx_valid = 1'b1; tx_data = SYX_EOX;                end
      default:  ;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      ch_q          <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      abort_q       <= 1'b0;
      data_held     <= 1'b0;
      data_q        <= '0;
      rej_pend      <= 1'b0;
      dump_done     <= 1'b0;
      dump_aborted  <= 1'b0;
      dump_rejected <= 1'b0;
    end else begin
      if (start_ok) begin
        ch_q   <= midi_ch;
        addr_q <= dump_addr;
        cnt_q  <= dump_len;
      end else if ((state == ST_DATA) && hs) begin
        addr_q <= addr_q + ADDR_W'(1);
        cnt_q  <= cnt_q - (ADDR_W+1)'(1);
      end

      if (state == ST_IDLE) begin
        abort_q <= 1'b0;
      end else if (dump_abort && abort_win) begin
        abort_q <= 1'b1;
      end

      data_held <= (state == ST_DATA) && !hs;
      if ((state == ST_DATA) && !data_held) begin
        data_q <= ram_q_masked;
      end

      dump_done    <= frame_end && !abort_q;
      dump_aborted <= frame_end &&  abort_q;

      // A start rejected in the F7 handshake cycle would land on the same
      // cycle as done/aborted; hold it back one cycle to keep pulses exclusive.
      if (frame_end) begin
        dump_rejected <= 1'b0;
        rej_pend      <= rej_pend | start_rej;
      end else begin
        dump_rejected <= rej_pend | start_rej;
        rej_pend      <= rej_pend & start_rej;
      end
    end
  end

endmodule

// File: tb/tb_midi_syx_dump_tx.sv
module tb_midi_syx_dump_tx;

  localparam int         ADDR_W = 8;
  localparam logic [7:0] MFR    = 8'h7D;

  logic              reg_clk = 1'b0;
  logic              reset_reg_N = 1'b0;
  logic [3:0]        midi_ch = '0;
  logic              dump_start = 1'b0;
  logic              dump_abort = 1'b0;
  logic [ADDR_W-1:0] dump_addr = '0;
  logic [ADDR_W:0]   dump_len = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q = 8'h00;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy, dump_done, dump_aborted, dump_rejected;

  midi_syx_dump_tx #(.MFR_ID(MFR), .ADDR_W(ADDR_W)) dut (
    .reg_clk       (reg_clk),
    .reset_reg_N   (reset_reg_N),
    .midi_ch       (midi_ch),
    .dump_start    (dump_start),
    .dump_abort    (dump_abort),
    .dump_addr     (dump_addr),
    .dump_len      (dump_len),
    .ram_addr      (ram_addr),
    .ram_rd        (ram_rd),
    .ram_q         (ram_q),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .dump_done     (dump_done),
    .dump_aborted  (dump_aborted),
    .dump_rejected (dump_rejected)
  );

  always #5 reg_clk = ~reg_clk;

  logic [7:0] ram [256];
  always @(posedge reg_clk) if (ram_rd) ram_q <= ram[ram_addr];

  int cyc = 0;
  always @(posedge reg_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  logic [7:0] got[$];
  int         hs_cyc[$];
  int         rd_addr[$];
  int n_done = 0, n_abrt = 0, n_rej = 0;
  int done_cyc = -1, abrt_cyc = -1, first_v = -1;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge reg_clk) begin
    if (prev_stall && reset_reg_N) begin
      check("hold_valid", tx_valid, 1'b1);
      check("hold_data", tx_data, prev_data);
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (dump_done | dump_aborted | dump_rejected)
      check("pulse_excl", $countones({dump_done, dump_aborted, dump_rejected}), 1);
    if (tx_valid && first_v < 0) first_v = cyc;
    if (tx_valid && tx_ready) begin
      got.push_back(tx_data);
      hs_cyc.push_back(cyc);
    end
    if (ram_rd) rd_addr.push_back(int'(ram_addr));
    if (dump_done)     begin n_done++; done_cyc = cyc; end
    if (dump_aborted)  begin n_abrt++; abrt_cyc = cyc; end
    if (dump_rejected) n_rej++;
  end

  task automatic clear_mon();
    got.delete(); hs_cyc.delete(); rd_addr.delete();
    n_done = 0; n_abrt = 0; n_rej = 0;
    done_cyc = -1; abrt_cyc = -1; first_v = -1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];

  function automatic void model(input logic [3:0] ch, input int addr, input int len, input int abort_after);
    int sum;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hF0);
    exp_q.push_back(MFR);
    exp_q.push_back({4'h0, ch});
    exp_q.push_back(8'h12);
    exp_q.push_back(8'((addr / 128) % 128));
    exp_q.push_back(8'(addr % 128));
    sum = (addr / 128) % 128 + addr % 128;
    for (int i = 0; i < len; i++) begin
      b = ram[(addr + i) % 256] & 8'h7F;
      exp_q.push_back(b);
      sum += int'(b);
      if (abort_after == i + 1) begin
        exp_q.push_back(8'hF7);
        return;
      end
    end
    exp_q.push_back(8'((128 - sum % 128) % 128));
    exp_q.push_back(8'hF7);
  endfunction

  // ---------------- stimulus helpers ----------------
  int start_c = 0;
  bit timed_out = 0;

  task automatic drive_start(input logic [3:0] ch, input int addr, input int len);
    @(posedge reg_clk); #1;
    dump_start = 1'b1;
    midi_ch    = ch;
    dump_addr  = ADDR_W'(addr);
    dump_len   = (ADDR_W+1)'(len);
    start_c    = cyc;
    @(posedge reg_clk); #1;
    dump_start = 1'b0;
  endtask

  task automatic finish_frame(input int abort_after, input bit rnd);
    int b;
    bit ab_sent;
    b = 0; ab_sent = 0; timed_out = 0;
    while (n_done == 0 && n_abrt == 0) begin
      if (b >= 3000) begin timed_out = 1; break; end
      tx_ready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_abort = (abort_after > 0) && !ab_sent && (got.size() == 6 + abort_after);
      if (dump_abort) ab_sent = 1;
      @(posedge reg_clk); #1;
      b++;
    end
    dump_abort = 1'b0;
    tx_ready   = 1'b0;
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = -1;
    check({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_bytes: byte %0d got %02h expected %02h", tag, bad, got[bad], exp_q[bad]);
    end
  endtask

  task automatic check_frame(input string tag, input int addr, input int len, input int abort_after, input bit timing);
    int nrd, bad;
    check({tag, "_timeout"}, timed_out, 0);
    cmp_stream(tag);
    check({tag, "_done"},    n_done, (abort_after > 0) ? 0 : 1);
    check({tag, "_aborted"}, n_abrt, (abort_after > 0) ? 1 : 0);
    if (hs_cyc.size() > 0) begin
      if (abort_after > 0) check({tag, "_abrt_cyc"}, abrt_cyc, hs_cyc[$] + 1);
      else                 check({tag, "_done_cyc"}, done_cyc, hs_cyc[$] + 1);
      if (timing) begin
        check({tag, "_f0_lat"}, first_v, start_c + 1);
        if (abort_after == 0) check({tag, "_frame_cyc"}, hs_cyc[$] - first_v + 1, 8 + 2 * len);
      end
    end
    nrd = (abort_after > 0) ? abort_after + 1 : len;
    check({tag, "_nreads"}, rd_addr.size(), nrd);
    bad = -1;
    for (int i = 0; i < rd_addr.size() && i < nrd; i++)
      if (bad < 0 && rd_addr[i] != (addr + i) % 256) bad = i;
    check({tag, "_rd_addr_err_idx"}, bad, -1);
    check({tag, "_busy_after"}, busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input logic [3:0] ch, input int addr, input int len,
                           input int abort_after, input bit rnd);
    model(ch, addr, len, abort_after);
    clear_mon();
    tx_ready = 1'b1;
    drive_start(ch, addr, len);
    finish_frame(abort_after, rnd);
    check_frame(tag, addr, len, abort_after, !rnd);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] ch;
    int         addr;
    int         len;
    int         abort_after;
    int         exp_csum;   // -1: no checksum byte to check
    int         exp_nbytes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h05] = 8'h10; ram[8'h06] = 8'h20;
    ram[8'hFF] = 8'h9A; ram[8'h00] = 8'h01;
    ram[8'h7E] = 8'h80; ram[8'h40] = 8'hC0;

    vecs[0] = '{ch: 4'h3, addr: 'h05, len: 2,   abort_after: 0, exp_csum: 'h4B, exp_nbytes: 10};
    vecs[1] = '{ch: 4'h0, addr: 'hFF, len: 2,   abort_after: 0, exp_csum: 'h65, exp_nbytes: 10};
    vecs[2] = '{ch: 4'hF, addr: 'h10, len: 4,   abort_after: 1, exp_csum: -1,   exp_nbytes: 8};
    vecs[3] = '{ch: 4'h5, addr: 'h7E, len: 1,   abort_after: 0, exp_csum: 'h02, exp_nbytes: 9};
    vecs[4] = '{ch: 4'h1, addr: 'h40, len: 1,   abort_after: 0, exp_csum: 'h00, exp_nbytes: 9};
    vecs[5] = '{ch: 4'h9, addr: 'h80, len: 256, abort_after: 0, exp_csum: -1,   exp_nbytes: 264};

    // reset state
    #12;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_outs", {tx_data, ram_addr, ram_rd, dump_done, dump_aborted, dump_rejected}, '0);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].ch, vecs[i].addr, vecs[i].len,
                vecs[i].abort_after, 1'b0);
      check($sformatf("vec%0d_nbytes_tbl", i), got.size(), vecs[i].exp_nbytes);
      if (vecs[i].exp_csum >= 0 && got.size() >= 2)
        check($sformatf("vec%0d_csum_tbl", i), got[got.size() - 2], vecs[i].exp_csum);
    end

    // backpressure on F0
    model(4'h6, 'h22, 3, 0);
    clear_mon();
    tx_ready = 1'b0;
    drive_start(4'h6, 'h22, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge reg_clk);
      check("bp_valid", tx_valid, 1'b1);
      check("bp_data",  tx_data,  8'hF0);
      @(posedge reg_clk); #1;
    end
    finish_frame(0, 1'b0);
    check_frame("bp", 'h22, 3, 0, 1'b0);
    if (got.size() > 1) check("bp_second_byte", got[1], MFR);

    // start while busy, then start with len 0
    model(4'h2, 'h31, 3, 0);
    clear_mon();
    tx_ready = 1'b1;
    drive_start(4'h2, 'h31, 3);
    @(posedge reg_clk); #1;
    dump_start = 1'b1; midi_ch = 4'hA; dump_addr = 8'h99; dump_len = 9'd5;
    @(posedge reg_clk); #1;
    dump_start = 1'b0;
    finish_frame(0, 1'b0);
    check_frame("rej_busy", 'h31, 3, 0, 1'b0);
    check("rej_busy_count", n_rej, 1);
    clear_mon();
    @(posedge reg_clk); #1;
    dump_start = 1'b1; dump_len = '0;
    @(posedge reg_clk); #1;
    dump_start = 1'b0;
    repeat (3) @(posedge reg_clk);
    #1;
    check("rej_len0_count", n_rej, 1);
    check("rej_len0_busy",  busy, 1'b0);
    check("rej_len0_bytes", got.size(), 0);

    // start arriving in the F7 handshake cycle
    model(4'h4, 'h50, 1, 0);
    clear_mon();
    tx_ready = 1'b1;
    drive_start(4'h4, 'h50, 1);
    for (int k = 0; k < 50; k++) begin
      if (tx_valid && tx_data == 8'hF7) begin
        dump_start = 1'b1; dump_len = 9'd2;
        @(posedge reg_clk); #1;
        dump_start = 1'b0;
        break;
      end
      @(posedge reg_clk); #1;
    end
    repeat (4) @(posedge reg_clk);
    #1;
    tx_ready = 1'b0;
    cmp_stream("f7_start");
    check("f7_start_done", n_done, 1);
    check("f7_start_rej",  n_rej,  1);
    check("f7_start_busy", busy,   1'b0);

    // reset during DATA
    clear_mon();
    tx_ready = 1'b1;
    drive_start(4'h7, 'h60, 4);
    for (int k = 0; k < 50 && !ram_rd; k++) begin
      @(posedge reg_clk); #1;
    end
    tx_ready = 1'b0;
    @(posedge reg_clk); #1;
    check("rst_mid_in_data", tx_valid, 1'b1);
    #2;
    reset_reg_N = 1'b0;
    #1;
    check("rst_mid_valid", tx_valid, 1'b0);
    check("rst_mid_busy",  busy,     1'b0);
    check("rst_mid_ram_rd", ram_rd,  1'b0);
    repeat (2) @(posedge reg_clk);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    repeat (2) @(posedge reg_clk);
    #1;
    check("rst_mid_no_f7", got.size(), 6);
    check("rst_mid_no_pulse", n_done + n_abrt, 0);
    run_frame("post_rst", 4'h7, 'h60, 4, 0, 1'b0);

    // randomized frames with random backpressure and aborts
    for (int i = 0; i < 20; i++) begin
      int a, l, ab;
      a  = $urandom_range(0, 255);
      l  = $urandom_range(1, 20);
      ab = (l > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, l - 1) : 0;
      run_frame($sformatf("rnd%0d", i), 4'($urandom), a, l, ab, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
